spsram_master: RTL and testbench

//  Initiator side of the single-port SRAM pin interface (cen/wen/oen, active-high enables).

---
 rtl/spsram_pkg.sv | 37 +++
 rtl/spsram_rsp_fifo.sv | 76 +++++++
 rtl/spsram_master.sv | 170 +++++++++++++++++
 tb/tb_spsram_master.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spsram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spsram_pkg                                                      |
// | Purpose  : Shared constants for the single-port SRAM initiator: default    |
// |            bus widths, request opcode encoding, and the read-return        |
// |            latency of the attached SRAM.                                   |
// | Config   : SPSRAM_MASTER_ASYNC_EN - defined when the SRAM uses its         |
// |            asynchronous read path (1-cycle return); undefined selects the  |
// |            registered read path (2-cycle return).                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package spsram_pkg;

   localparam int DEF_BW_DATA = 32;
   localparam int DEF_BW_ADDR = 8;

   // Request opcode carried on i_req_we.
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // Edges from a read handshake until the returned word is pushed to the
   // response FIFO; also the length of the return-valid shift pipe.
`ifdef SPSRAM_MASTER_ASYNC_EN
   localparam int RD_LATENCY = 1;
`else
   localparam int RD_LATENCY = 2;
`endif

   // Credit counter must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spsram_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spsram_rsp_fifo                                                 |
// | Purpose  : Synchronous DEPTH x WIDTH FIFO holding read responses in order. |
// |            Push and pop in the same cycle are both honoured. The head is   |
// |            presented combinationally and reads as zero while empty.        |
// | Ports    : i_clk, i_rstn (async active-low), i_push/i_push_data,           |
// |            i_pop/o_pop_data, o_empty, o_full                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spsram_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_depth);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop  && !o_empty;

   // Zero while empty so the response data port has a defined reset value
   // without having to clear the storage array.
   assign o_pop_data = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_cnt_one;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - c_cnt_one;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spsram_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spsram_master                                                   |
// | Purpose  : Initiator for the single-port SRAM pin interface. Accepts       |
// |            read/write requests on a valid/ready port, drives registered    |
// |            cen/wen/oen/addr/data, and returns read data in request order   |
// |            through a credit-gated response FIFO.                           |
// | Ports    : i_clk, i_rstn (async active-low)                                |
// |            request : i_req_valid, o_req_ready, i_req_we, i_req_addr,       |
// |                      i_req_data                                            |
// |            response: o_rsp_valid, i_rsp_ready, o_rsp_data                  |
// |            SRAM    : o_sram_cen, o_sram_wen, o_sram_oen, o_sram_addr,      |
// |                      o_sram_data, i_sram_data                              |
// |            status  : o_busy                                                |
// | Config   : SPSRAM_MASTER_ASYNC_EN selects the 1-stage return pipe for an   |
// |            asynchronous-read SRAM; default is the 2-stage pipe.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spsram_master
   import spsram_pkg::*;
#(
   parameter int BW_DATA   = DEF_BW_DATA,
   parameter int BW_ADDR   = DEF_BW_ADDR,
   parameter int RSP_DEPTH = 4
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_we,
   input  logic [BW_ADDR-1:0] i_req_addr,
   input  logic [BW_DATA-1:0] i_req_data,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [BW_DATA-1:0] o_rsp_data,
   output logic               o_sram_cen,
   output logic               o_sram_wen,
   output logic               o_sram_oen,
   output logic [BW_ADDR-1:0] o_sram_addr,
   output logic [BW_DATA-1:0] o_sram_data,
   input  logic [BW_DATA-1:0] i_sram_data,
   output logic               o_busy
);

   localparam int CW = cnt_width(RSP_DEPTH);

   localparam logic [CW-1:0] c_depth   = CW'(RSP_DEPTH);
   localparam logic [CW-1:0] c_cnt_one = CW'(1);

   // ------------------------------------------------------------------
   // Handshakes and credits
   // ------------------------------------------------------------------
   logic          w_is_write;
   logic          w_req_hs;
   logic          w_rd_hs;
   logic          w_rsp_pop;
   logic [CW-1:0] r_cnt;

   assign w_is_write  = (op_e'(i_req_we) == OP_WRITE);
   // A credit covers a read from acceptance until its response is popped,
   // so the FIFO can never be asked to hold more than RSP_DEPTH words.
   assign o_req_ready = (r_cnt < c_depth);
   assign w_req_hs    = i_req_valid && o_req_ready;
   assign w_rd_hs     = w_req_hs && !w_is_write;
   assign w_rsp_pop   = o_rsp_valid && i_rsp_ready;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt <= '0;
      end else if (w_rd_hs && !w_rsp_pop) begin
         r_cnt <= r_cnt + c_cnt_one;
      end else if (!w_rd_hs && w_rsp_pop) begin
         r_cnt <= r_cnt - c_cnt_one;
      end
   end

   // ------------------------------------------------------------------
   // Issue stage: SRAM controls are registered one edge after acceptance
   // ------------------------------------------------------------------
   logic               r_sram_cen;
   logic               r_sram_wen;
   logic               r_sram_oen;
   logic [BW_ADDR-1:0] r_sram_addr;
   logic [BW_DATA-1:0] r_sram_data;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_sram_cen  <= 1'b0;
         r_sram_wen  <= 1'b0;
         r_sram_oen  <= 1'b0;
         r_sram_addr <= '0;
         r_sram_data <= '0;
      end else begin
         r_sram_cen <= w_req_hs;
         r_sram_wen <= w_req_hs && w_is_write;
         r_sram_oen <= w_req_hs && !w_is_write;
         // Address/data hold between requests to avoid needless toggling.
         if (w_req_hs) begin
            r_sram_addr <= i_req_addr;
            r_sram_data <= i_req_data;
         end
      end
   end

   assign o_sram_cen  = r_sram_cen;
   assign o_sram_wen  = r_sram_wen;
   assign o_sram_oen  = r_sram_oen;
   assign o_sram_addr = r_sram_addr;
   assign o_sram_data = r_sram_data;

   // ------------------------------------------------------------------
   // Return-valid pipe: marks the cycle in which i_sram_data carries the
   // word for an accepted read. Bit 0 loads on the read handshake; the
   // last bit qualifies the FIFO push.
   // ------------------------------------------------------------------
   logic [RD_LATENCY-1:0] r_ret_vld;
   logic                  w_ret_push;

   generate
      if (RD_LATENCY > 1) begin : g_ret_pipe_multi
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_ret_vld <= '0;
            end else begin
               r_ret_vld <= {r_ret_vld[RD_LATENCY-2:0], w_rd_hs};
            end
         end
      end else begin : g_ret_pipe_single
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_ret_vld <= '0;
            end else begin
               r_ret_vld <= w_rd_hs;
            end
         end
      end
   endgenerate

   assign w_ret_push = r_ret_vld[RD_LATENCY-1];

   // ------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------
   logic w_fifo_empty;
   logic w_fifo_full;
   logic w_fifo_push;

   // Credits already exclude a push into a full FIFO; the full term only
   // keeps the storage safe if the credit logic were ever bypassed.
   assign w_fifo_push = w_ret_push && !w_fifo_full;

   spsram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (BW_DATA)
   ) u_rsp_fifo (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_push      (w_fifo_push),
      .i_push_data (i_sram_data),
      .i_pop       (w_rsp_pop),
      .o_pop_data  (o_rsp_data),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

   assign o_rsp_valid = !w_fifo_empty;
   assign o_busy      = r_sram_cen || (|r_ret_vld) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_spsram_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spsram_master                                                |
// | Purpose  : Self-checking bench for spsram_master with an attached SRAM     |
// |            model, a queue-based reference of read results and an           |
// |            independent response monitor.                                   |
// | Config   : SPSRAM_MASTER_ASYNC_EN selects the asynchronous-read SRAM model |
// |            and a 1-cycle expected read latency.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_spsram_master;

   localparam int BW_DATA   = 32;
   localparam int BW_ADDR   = 8;
   localparam int RSP_DEPTH = 4;
`ifdef SPSRAM_MASTER_ASYNC_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   logic               clk = 1'b0;
   logic               rstn;
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [BW_ADDR-1:0] req_addr;
   logic [BW_DATA-1:0] req_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [BW_DATA-1:0] rsp_data;
   logic               sram_cen;
   logic               sram_wen;
   logic               sram_oen;
   logic [BW_ADDR-1:0] sram_addr;
   logic [BW_DATA-1:0] sram_wdata;
   logic [BW_DATA-1:0] sram_rdata;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spsram_master #(
      .BW_DATA   (BW_DATA),
      .BW_ADDR   (BW_ADDR),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_data  (req_data),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_data  (rsp_data),
      .o_sram_cen  (sram_cen),
      .o_sram_wen  (sram_wen),
      .o_sram_oen  (sram_oen),
      .o_sram_addr (sram_addr),
      .o_sram_data (sram_wdata),
      .i_sram_data (sram_rdata),
      .o_busy      (busy)
   );

   // ---------------- attached SRAM model ----------------
   logic [BW_DATA-1:0] sram_mem [256];
`ifdef SPSRAM_MASTER_ASYNC_EN
   always @(posedge clk) begin
      if (sram_cen && sram_wen) sram_mem[sram_addr] <= sram_wdata;
   end
   assign sram_rdata = (sram_cen && sram_oen) ? sram_mem[sram_addr] : 32'h0BAD_F00D;
`else
   logic [BW_DATA-1:0] sram_q;
   always @(posedge clk) begin
      if (sram_cen) begin
         if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
         else          sram_q <= sram_mem[sram_addr];
      end
   end
   assign sram_rdata = sram_q;
`endif

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard push ----------------
   // Memory contents as seen in request order: a read returns whatever the
   // most recent accepted write to that address stored.
   logic [BW_DATA-1:0] ref_mem [256];
   logic [BW_DATA-1:0] exp_q [$];

   always @(negedge clk) begin
      if (rstn && req_valid && req_ready) begin
         if (req_we) ref_mem[req_addr] <= req_data;
         else        exp_q.push_back(ref_mem[req_addr]);
      end
   end

   // ---------------- response monitor ----------------
   logic               hold_prev = 1'b0;
   logic [BW_DATA-1:0] data_prev = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            chk("rsp_valid_hold", {63'd0, rsp_valid}, 64'd1);
            chk("rsp_data_hold", {32'd0, rsp_data}, {32'd0, data_prev});
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rsp_unexpected actual=%0h required=no_response t=%0t", rsp_data, $time);
            end else begin
               chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_q.pop_front()});
            end
         end
         hold_prev <= rsp_valid && !rsp_ready;
         data_prev <= rsp_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic send(input logic we, input logic [7:0] addr, input logic [31:0] data);
      int waited;
      bit got;
      waited = 0;
      got    = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_data  = data;
      while (!got && waited < 100) begin
         @(negedge clk);
         got = req_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout actual=no_handshake required=handshake addr=%0h", addr);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Waits for the next response, checks it directly, then pops it.
   task automatic pop_one(input string name, input logic [31:0] exp, output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(name, {32'd0, rsp_data}, {32'd0, exp});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat, acc, pops, drain_cyc, stray;
      bit hs;

      rstn      = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      rsp_ready = 1'b0;

      // Reset held with random inputs.
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         req_valid = 1'($urandom_range(0, 1));
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 8'($urandom);
         req_data  = $urandom;
         rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("rst_cen",      {63'd0, sram_cen}, 64'd0);
      chk("rst_wen",      {63'd0, sram_wen}, 64'd0);
      chk("rst_oen",      {63'd0, sram_oen}, 64'd0);
      chk("rst_addr",     {56'd0, sram_addr}, 64'd0);
      chk("rst_wdata",    {32'd0, sram_wdata}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("rst_busy",     {63'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      #2 rstn = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Preload addresses 0..31; 0..7 hold 0xA0+addr.
      for (int a = 0; a < 32; a++) begin
         send(1'b1, 8'(a), (a < 8) ? 32'(32'hA0 + a) : $urandom);
      end
      req_valid = 1'b0;
      cycles(2);

      // Write then read the same address; measure read latency.
      send(1'b1, 8'h10, 32'hDEAD_BEEF);
      send(1'b0, 8'h10, 32'h0);
      req_valid = 1'b0;
      pop_one("rd_data_deadbeef", 32'hDEAD_BEEF, lat);
      chk("rd_latency", 64'(lat), 64'(EXP_LAT));

      // Read-after-write on consecutive handshakes; oen low during write.
      send(1'b1, 8'h20, 32'h55);
      chk("wr_cycle_cen", {63'd0, sram_cen}, 64'd1);
      chk("wr_cycle_wen", {63'd0, sram_wen}, 64'd1);
      chk("wr_cycle_oen", {63'd0, sram_oen}, 64'd0);
      send(1'b0, 8'h20, 32'h0);
      chk("rd_cycle_oen", {63'd0, sram_oen}, 64'd1);
      chk("rd_cycle_addr", {56'd0, sram_addr}, 64'h20);
      req_valid = 1'b0;
      pop_one("raw_data", 32'h55, lat);

      // Back-to-back reads of 0..7 with the consumer stalled.
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 8'(acc);
         @(negedge clk);
         hs = req_ready;
         @(posedge clk);
         #1;
         if (hs) acc++;
      end
      chk("accepted_while_stalled", 64'(acc), 64'd4);
      chk("ready_low_when_full", {63'd0, req_ready}, 64'd0);
      rsp_ready = 1'b1;
      pops = 0;
      drain_cyc = 0;
      for (int c = 0; c < 40 && pops < 8; c++) begin
         req_valid = (acc < 8);
         req_addr  = 8'(acc);
         @(negedge clk);
         hs = req_valid && req_ready;
         if (rsp_valid) pops++;
         @(posedge clk);
         #1;
         if (hs) acc++;
         drain_cyc++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("drain_pops", 64'(pops), 64'd8);
      chk("drain_cycles", 64'(drain_cyc), 64'd8);

      // Three reads outstanding, then a read handshake and a pop together.
      send(1'b0, 8'd8, 32'h0);
      send(1'b0, 8'd9, 32'h0);
      send(1'b0, 8'd10, 32'h0);
      req_valid = 1'b0;
      cycles(EXP_LAT + 1);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'd11;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("simul_pre_ready", {63'd0, req_ready}, 64'd1);
      chk("simul_pre_valid", {63'd0, rsp_valid}, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("simul_post_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 8'(12 + acc);
         @(negedge clk);
         hs = req_ready;
         @(posedge clk);
         #1;
         if (hs) acc++;
      end
      req_valid = 1'b0;
      chk("simul_extra_accept", 64'(acc), 64'd1);
      rsp_ready = 1'b1;
      pops = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid) pops++;
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b0;
      chk("simul_drain_pops", 64'(pops), 64'd4);

      // Reset pulse with reads in flight.
      send(1'b0, 8'd1, 32'h0);
      send(1'b0, 8'd2, 32'h0);
      send(1'b0, 8'd3, 32'h0);
      req_valid = 1'b0;
      chk("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
      chk("pre_rst_cen", {63'd0, sram_cen}, 64'd1);
      #3 rstn = 1'b0;
      #1;
      chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_cen", {63'd0, sram_cen}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      exp_q.delete();
      @(posedge clk);
      #4 rstn = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid) stray++;
         @(posedge clk);
         #1;
      end
      chk("no_stale_rsp", 64'(stray), 64'd0);
      chk("ready_after_midrst", {63'd0, req_ready}, 64'd1);

      // Randomized traffic over the preloaded address range.
      for (int c = 0; c < 400; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 8'($urandom_range(0, 31));
         req_data  = $urandom;
         rsp_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 50 && (exp_q.size() != 0 || busy); c++) begin
         @(posedge clk);
         #1;
      end
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("final_busy", {63'd0, busy}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
